// File: rtl/cenn_output_collector.sv
// cenn_output_collector
//   Consumer end of the CeNN chain. It drops the pipeline-fill samples at the start of a frame.
//   It turns each remaining signed fixed-point sample into an 8-bit pixel, buffers the pixels in
//   a small FIFO and hands them downstream over a valid/ready handshake.
//   Build option CENN_BINARIZE_EN: the linear conversion is replaced by a sign threshold
//   (>=0 -> 255, <0 -> 0). Latency is the same in both builds.
// Ports
//   clk, rst       rising-edge clock, synchronous active-high reset
//   start          pulse that arms a frame; ignored while busy
//   ready_fixed    sample strobe; out_cenn_x is valid in the same cycle
//   out_cenn_x     signed fixed-point sample (width bits, bit_fractional fraction bits)
//   pix_data       pixel at the FIFO head (0 when the FIFO is empty)
//   pix_valid      FIFO not empty
//   pix_ready      downstream accept
//   busy           frame in progress
//   frame_done     one-cycle pulse after the last pixel of a frame is popped
//   overflow       sticky: a pixel was dropped because the FIFO was full
module cenn_output_collector #(
  parameter int width          = 15,
  parameter int bit_fractional = 9,
  parameter int skip_samples   = 2050,
  parameter int frame_pixels   = 1048576,
  parameter int fifo_depth     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ready_fixed,
  input  logic [width-1:0] out_cenn_x,
  output logic [7:0]       pix_data,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             busy,
  output logic             frame_done,
  output logic             overflow
);
  localparam int MAXC = (skip_samples > frame_pixels) ? skip_samples : frame_pixels;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int AW   = $clog2(fifo_depth);
  localparam logic [CW-1:0] SKIP_LAST = CW'((skip_samples > 0) ? skip_samples - 1 : 0);
  localparam logic [CW-1:0] PIX_LAST  = CW'(frame_pixels - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(fifo_depth);

  typedef enum logic [1:0] {IDLE, SKIP, COLLECT, DRAIN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [7:0]    mem [fifo_depth];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [7:0]    pix_c;
  logic          push, pop, full, wr_en;

  // The conversion feeds the FIFO write port directly. The FIFO storage is the single
  // register stage, so a pixel is visible one cycle after its strobe.
`ifdef CENN_BINARIZE_EN
  always_comb pix_c = out_cenn_x[width-1] ? 8'd0 : 8'd255;
`else
  logic [width:0] v, p;
  always_comb begin
    // Shift by +1.0 so that -1.0 maps to 0. The width+1 bits cannot overflow here.
    v = {out_cenn_x[width-1], out_cenn_x} + ((width+1)'(1) << bit_fractional);
    p = v >> (bit_fractional - 7);
    if (v[width])                  pix_c = 8'd0;
    else if (p > (width+1)'(255))  pix_c = 8'd255;
    else                           pix_c = p[7:0];
  end
`endif

  assign push      = (state == COLLECT) && ready_fixed;
  assign full      = (count == FULL_CNT);
  assign pix_valid = (count != '0);
  assign pop       = pix_valid && pix_ready;
  // When the FIFO is full, a write is still allowed in a cycle that also pops.
  assign wr_en     = push && (!full || pop);
  assign busy      = (state != IDLE);
  assign pix_data  = pix_valid ? mem[rd_ptr] : 8'd0;

  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= pix_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(wr_en) - (AW+1)'(pop);
      if (push && full && !pop) overflow <= 1'b1;
      case (state)
        IDLE:
          if (start) begin
            overflow <= 1'b0;
            cnt      <= '0;
            state    <= (skip_samples > 0) ? SKIP : COLLECT;
          end
        SKIP:
          if (ready_fixed) begin
            if (cnt == SKIP_LAST) begin
              cnt   <= '0;
              state <= COLLECT;
            end else cnt <= cnt + 1'b1;
          end
        // A dropped pixel still counts, so the frame length stays fixed.
        COLLECT:
          if (ready_fixed) begin
            if (cnt == PIX_LAST) begin
              cnt   <= '0;
              state <= DRAIN;
            end else cnt <= cnt + 1'b1;
          end
        DRAIN:
          if (count == '0 || (count == (AW+1)'(1) && pop)) begin
            state      <= IDLE;
            frame_done <= 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cenn_output_collector.sv
module tb_cenn_output_collector;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b1, ready_fixed = 1'b0, pix_ready = 1'b0;
  logic [14:0] x = '0;
  logic [7:0]  pix_data;
  logic        pix_valid, busy, frame_done, overflow;

  int n_chk = 0, n_pass = 0;
  logic [7:0]  exp_q [$];
  logic [14:0] va [8];
  logic [7:0]  ea [8];
  logic [14:0] vd [8];
  logic [7:0]  ed [8];

  cenn_output_collector #(.width(15), .bit_fractional(9), .skip_samples(4),
                          .frame_pixels(8), .fifo_depth(4)) dut (
    .clk(clk), .rst(rst), .start(start), .ready_fixed(ready_fixed), .out_cenn_x(x),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready), .busy(busy),
    .frame_done(frame_done), .overflow(overflow));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d required %0d", nm, act, req);
  endtask

  // Scoreboard monitor: every accepted pixel must match the oldest expected one.
  always @(negedge clk) begin
    if (!rst && pix_valid && pix_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL extra_pixel: got %0d required none", pix_data);
      end else chk("pixel", pix_data, exp_q.pop_front());
    end
  end

  task automatic tick; @(posedge clk); #1; endtask
  task automatic do_start; start = 1'b1; tick(); start = 1'b0; endtask
  task automatic strobe(input logic [14:0] v, input bit accept, input logic [7:0] e);
    ready_fixed = 1'b1; x = v;
    if (accept) exp_q.push_back(e);
    tick();
    ready_fixed = 1'b0;
  endtask
  task automatic skips; repeat (4) strobe(15'h0, 1'b0, 8'd0); endtask
  task automatic wait_done(input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) begin seen = 1'b1; break; end
    end
    if (!seen) begin n_chk++; $display("FAIL %s_timeout: got busy required idle", nm); end
    chk({nm, "_done_pulse"}, frame_done, 1);
    @(negedge clk);
    chk({nm, "_done_low"}, frame_done, 0);
    chk({nm, "_queue_empty"}, exp_q.size(), 0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    va = '{15'h0200, 15'h7E00, 15'h0000, 15'h3FFF, 15'h4000, 15'h7F00, 15'h0100, 15'h7FFF};
    vd = '{15'h0001, 15'h01FF, 15'h0201, 15'h7E01, 15'h7DFF, 15'h0080, 15'h7F80, 15'h0004};
`ifdef CENN_BINARIZE_EN
    ea = '{8'd255, 8'd0, 8'd255, 8'd255, 8'd0, 8'd0, 8'd255, 8'd0};
    ed = '{8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd255};
`else
    ea = '{8'd255, 8'd0, 8'd128, 8'd255, 8'd0, 8'd64, 8'd192, 8'd127};
    ed = '{8'd128, 8'd255, 8'd255, 8'd0, 8'd0, 8'd160, 8'd96, 8'd129};
`endif

    // Reset with start held high: the start must be ignored.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pix_data", pix_data, 0);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_overflow", overflow, 0);
    tick(); rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("start_in_rst_ignored", busy, 0);
    tick();

    // Frame A: streaming with pix_ready held high.
    pix_ready = 1'b1;
    do_start();
    chk("a_busy", busy, 1);
    skips();
    chk("a_skip_no_pixel", pix_valid, 0);
    for (int i = 0; i < 8; i++) strobe(va[i], 1'b1, ea[i]);
    wait_done("a");
    chk("a_overflow", overflow, 0);

    // Frame B: stalled downstream. Six strobes leave four held pixels and two drops.
    pix_ready = 1'b0;
    do_start();
    skips();
    for (int i = 0; i < 6; i++) strobe(va[i], i < 4, ea[i]);
    @(negedge clk);
    chk("b_valid", pix_valid, 1);
    chk("b_overflow", overflow, 1);
    chk("b_head", pix_data, ea[0]);
    tick();
    @(negedge clk);
    chk("b_head_stable", pix_data, ea[0]);
    tick();
    do_start();
    chk("b_start_busy_ignored", overflow, 1);
    chk("b_still_busy", busy, 1);
    pix_ready = 1'b1;
    strobe(va[6], 1'b1, ea[6]);
    strobe(va[7], 1'b1, ea[7]);
    wait_done("b");
    chk("b_overflow_sticky", overflow, 1);

    // Frame C: a strobe that coincides with a pop while the FIFO is full is not dropped.
    pix_ready = 1'b0;
    do_start();
    @(negedge clk);
    chk("c_start_clears_ovf", overflow, 0);
    tick();
    skips();
    for (int i = 0; i < 4; i++) strobe(va[i], 1'b1, ea[i]);
    @(negedge clk);
    chk("c_full_valid", pix_valid, 1);
    tick();
    pix_ready = 1'b1;
    strobe(va[4], 1'b1, ea[4]);
    pix_ready = 1'b0;
    @(negedge clk);
    chk("c_no_drop", overflow, 0);
    chk("c_head_next", pix_data, ea[1]);
    tick();
    pix_ready = 1'b1;
    for (int i = 5; i < 8; i++) strobe(va[i], 1'b1, ea[i]);
    wait_done("c");
    chk("c_overflow", overflow, 0);

    // Frame D: reset in the middle of COLLECT, then a clean frame.
    pix_ready = 1'b0;
    do_start();
    skips();
    strobe(vd[0], 1'b1, ed[0]);
    strobe(vd[1], 1'b1, ed[1]);
    rst = 1'b1; start = 1'b1;
    tick();
    chk("d_rst_valid", pix_valid, 0);
    chk("d_rst_busy", busy, 0);
    chk("d_rst_data", pix_data, 0);
    exp_q.delete();
    tick();
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("d_after_rst_idle", busy, 0);
    tick();
    pix_ready = 1'b1;
    do_start();
    skips();
    for (int i = 0; i < 8; i++) strobe(vd[i], 1'b1, ed[i]);
    wait_done("d");
    chk("d_overflow", overflow, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
